div: RTL and testbench
======================

Name: div

Overview:
- Sequential MIX DIV unit (command 4): the inverse of the multiplier.
- Divides the signed double-word dividend rAX (rA:rX, sign taken from rA) by the signed word V.
- Produces quotient (destined for rA) and remainder (destined for rX).
- Uses the same start/stop sequencing as the other arithmetic units: the dividend is presented with start and the divisor one cycle later, after the memory fetch.

Parameters:
WIDTH, 30, magnitude bits of one MIX word (5 bytes x 6 bits); dividend magnitude is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a division and samples in1
in1  input  2*WIDTH+1  dividend {sign, rA magnitude, rX magnitude}; valid only in the start cycle
in2  input  WIDTH+1  divisor {sign, magnitude}; valid only in the cycle after start (start2)
quot  output  WIDTH+1  quotient {sign, magnitude}
rem  output  WIDTH+1  remainder {sign, magnitude}
overflow  output  1  division overflow flag; valid when stop is high, held until next start
stop  output  1  one-cycle pulse; quot, rem and overflow are valid from this cycle
busy  output  1  high from the cycle after start until the cycle before stop

Behaviour:
- Reset (asynchronous, active-high): start2, run, counter, stop, busy, overflow, quot, rem and all internal registers clear to 0.
- Timing, with start high in cycle T:
  - T: dividend latched, and sign_a := in1 sign.
  - T+1 (start2): divisor latched, and sign_q := sign_a ^ in2 sign.
  - Overflow test at the T+1 edge: overflow iff rA magnitude >= in2 magnitude. This includes divisor = 0.
- Overflow path:
  - stop pulses in T+2, overflow=1.
  - quot = {sign_a, original rA magnitude}, rem = {sign_a, original rX magnitude}, i.e. registers are written back unchanged.
  - No iterations run.
- Normal path:
  - Restoring radix-2 division, one quotient bit per cycle, WIDTH iterations in cycles T+2..T+WIDTH+1 (counter 0..WIDTH-1).
  - last = (counter == WIDTH-1).
  - stop pulses in cycle T+WIDTH+2 (T+32 by default), overflow=0.
- Iteration step:
  - Partial remainder r is WIDTH+1 bits, initialised to the rA magnitude; q shifter is initialised to the rX magnitude.
  - Each cycle: {r,q} shifts left 1, then trial = r - {0,divisor}.
  - If trial >= 0: r := trial and the new q LSB = 1; otherwise the LSB = 0.
  - Final values: quotient magnitude = q; remainder magnitude = r[WIDTH-1:0]. Since r < divisor, the top bit is 0.
- Signs:
  - quot sign = sign_a ^ sign_v.
  - rem sign = sign_a.
  - Zero magnitudes keep the computed sign (MIX minus-zero is legal).
- Outputs quot/rem/overflow update only at result time and hold until the next result. Intermediate iteration values do not appear on quot/rem.
- busy is high from T+1 until the cycle before stop (the last iteration cycle, or T+1 on overflow). It is low in the stop cycle.
- Restart: start while busy aborts the current division. No stop is issued for the aborted one; the new operation restarts at T.
- start in the same cycle as stop is legal. stop still pulses for the finished operation, and the new operation begins.
- Reset mid-operation: immediate clear. No stop is produced for the aborted operation.
- in2 is ignored except in start2; in1 is ignored except in start.

Test Plan:
- Small division. in1 = {+, rA=0, rX=17}, in2 = +3 -> stop at T+32, quot = +5, rem = +2, overflow = 0, busy high T+1..T+31.
- Signs. in1 = {-, 0, 100}, in2 = +7 -> quot = -14, rem = -2. Same dividend with in2 = -7 -> quot = +14, rem = -2.
- Overflow. in1 = {+, rA=5, rX=9}, in2 = +5 -> stop at T+2, overflow = 1, quot = +5, rem = +9. in2 = +0 -> overflow = 1 at T+2.
- Maximum operands. rA = 0x3FFFFFFE, rX = 0x3FFFFFFF, in2 = +0x3FFFFFFF -> quot = +0x3FFFFFFF, rem = +0x3FFFFFFE, overflow = 0.
- Restart. start at T, second start at T+10 with in1 = {+, 0, 17} and in2 = +3 -> single stop at T+42 with quot = +5, rem = +2; no stop at T+32.
- Reset. Assert reset at T+15 of a division -> all outputs 0 immediately, no stop. After release, a fresh start gives a correct result at +32 cycles.

Source files
------------

// File: rtl/div_if.sv
// Operand/result bundle for the MIX DIV unit.
interface div_if #(
    parameter int WIDTH = 30
);
    logic               start;
    logic [2*WIDTH:0]   in1;
    logic [WIDTH:0]     in2;
    logic [WIDTH:0]     quot;
    logic [WIDTH:0]     rem;
    logic               overflow;
    logic               stop;
    logic               busy;

    modport master (output start, in1, in2,
                    input  quot, rem, overflow, stop, busy);
    modport slave  (input  start, in1, in2,
                    output quot, rem, overflow, stop, busy);
endinterface

// File: rtl/div.sv
// Sequential MIX DIV: signed double-word rA:rX divided by signed word V,
// restoring radix-2, one quotient bit per cycle.
module div #(
    parameter int WIDTH = 30
) (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_START2, S_RUN} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_hi, a_lo, dvs, q;
    logic [WIDTH:0]    r;
    logic              sign_a, sign_q;
    logic [CW-1:0]     counter;
    logic [WIDTH:0]    quot_r, rem_r;
    logic              overflow_r, stop_r;

    logic              last, ovf_now;
    logic [WIDTH:0]    r_sh, r_step;
    logic [WIDTH-1:0]  q_step;
    logic [WIDTH+1:0]  trial;

    assign last    = (counter == CW'(WIDTH - 1));
    assign ovf_now = (a_hi >= bus.in2[WIDTH-1:0]);

    // One restoring step: shift {r,q} left, keep the trial difference if non-negative.
    always_comb begin
        r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
        trial  = {1'b0, r_sh} - {2'b00, dvs};
        r_step = r_sh;
        q_step = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            r_step = trial[WIDTH:0];
            q_step = {q[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state; a new start always wins and restarts the sequence.
    always_comb begin
        state_n = state;
        if (bus.start) begin
            state_n = S_START2;
        end else begin
            case (state)
                S_START2: state_n = ovf_now ? S_IDLE : S_RUN;
                S_RUN:    if (last) state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // Operand capture, iteration and result write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_hi       <= '0;
            a_lo       <= '0;
            dvs        <= '0;
            q          <= '0;
            r          <= '0;
            sign_a     <= 1'b0;
            sign_q     <= 1'b0;
            counter    <= '0;
            quot_r     <= '0;
            rem_r      <= '0;
            overflow_r <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            stop_r <= 1'b0;
            if (bus.start) begin
                sign_a <= bus.in1[2*WIDTH];
                a_hi   <= bus.in1[2*WIDTH-1:WIDTH];
                a_lo   <= bus.in1[WIDTH-1:0];
            end else begin
                case (state)
                    S_START2: begin
                        dvs     <= bus.in2[WIDTH-1:0];
                        sign_q  <= sign_a ^ bus.in2[WIDTH];
                        r       <= {1'b0, a_hi};
                        q       <= a_lo;
                        counter <= '0;
                        if (ovf_now) begin
                            stop_r     <= 1'b1;
                            overflow_r <= 1'b1;
                            quot_r     <= {sign_a, a_hi};
                            rem_r      <= {sign_a, a_lo};
                        end
                    end
                    S_RUN: begin
                        r       <= r_step;
                        q       <= q_step;
                        counter <= counter + 1'b1;
                        if (last) begin
                            stop_r     <= 1'b1;
                            overflow_r <= 1'b0;
                            quot_r     <= {sign_q, q_step};
                            rem_r      <= {sign_a, r_step[WIDTH-1:0]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.quot     = quot_r;
    assign bus.rem      = rem_r;
    assign bus.overflow = overflow_r;
    assign bus.stop     = stop_r;
    assign bus.busy     = (state != S_IDLE);
endmodule

// File: tb/tb_div.sv
// Self-checking bench for the MIX DIV unit.
module tb_div;
    localparam int W = 30;

    typedef struct {
        bit          valid;
        int          start_cyc;
        int          stop_cyc;
        logic [W:0]  q;
        logic [W:0]  r;
        logic        ovf;
    } exp_t;

    logic clk, reset;
    int   cyc = 0;
    int   checks = 0, failures = 0;
    exp_t pend;
    logic [W:0] held_q, held_r;
    logic       held_ovf;
    int   last_stop_cyc = -1;

    div_if #(.WIDTH(W)) bus();
    div #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer division of the 2W-bit magnitude.
    function automatic exp_t model(input bit sa, input logic [W-1:0] ra, input logic [W-1:0] rx,
                                   input bit sv, input logic [W-1:0] v);
        exp_t e;
        longint unsigned dd;
        e.valid = 1'b1;
        e.start_cyc = 0;
        e.stop_cyc = 0;
        e.ovf = (ra >= v);
        if (e.ovf) begin
            e.q = {sa, ra};
            e.r = {sa, rx};
        end else begin
            dd  = {4'b0, ra, rx};
            e.q = {sa ^ sv, W'(dd / longint'(v))};
            e.r = {sa, W'(dd % longint'(v))};
        end
        return e;
    endfunction

    // Per-cycle compare against the expected pending operation and held results.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", bus.busy, pend.valid && cyc > pend.start_cyc && cyc < pend.stop_cyc);
            chk("stop", bus.stop, pend.valid && cyc == pend.stop_cyc);
            if (pend.valid && cyc == pend.stop_cyc) begin
                held_q   = pend.q;
                held_r   = pend.r;
                held_ovf = pend.ovf;
                pend.valid = 1'b0;
                if (bus.stop) last_stop_cyc = cyc;
            end
            chk("quot", bus.quot, held_q);
            chk("rem", bus.rem, held_r);
            chk("overflow", bus.overflow, held_ovf);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input bit sa, input logic [W-1:0] ra, input logic [W-1:0] rx,
                            input bit sv, input logic [W-1:0] v);
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in1   = {sa, ra, rx};
        e = model(sa, ra, rx, sv, v);
        e.start_cyc = cyc;
        e.stop_cyc  = cyc + (e.ovf ? 2 : W + 2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in1   = {$urandom, $urandom};
        bus.in2   = {sv, v};
        pend = e;
        @(posedge clk); #1;
        bus.in2   = (W+1)'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (pend.valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", pend.valid, 1'b0);
        pend.valid = 1'b0;
    endtask

    initial begin
        exp_t m;
        int t0, s;

        pend.valid = 1'b0;
        held_q = '0; held_r = '0; held_ovf = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;

        // Pin the model with hand-computed values.
        m = model(1'b0, 30'd0, 30'd17, 1'b0, 30'd3);
        chk("model_q_17_3", m.q, 31'h5);
        chk("model_r_17_3", m.r, 31'h2);
        m = model(1'b1, 30'd0, 30'd100, 1'b1, 30'd7);
        chk("model_q_sign", m.q, 31'h0000000E);
        chk("model_r_sign", m.r, 31'h40000002);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_quot", bus.quot, 0);
        chk("rst_rem", bus.rem, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_stop", bus.stop, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;

        // Small division.
        start_op(1'b0, 30'd0, 30'd17, 1'b0, 30'd3);
        t0 = pend.start_cyc;
        wait_done();
        chk("small_quot", held_q, 31'h5);
        chk("small_rem", held_r, 31'h2);
        chk("small_lat", last_stop_cyc - t0, 32);

        // Signs.
        start_op(1'b1, 30'd0, 30'd100, 1'b0, 30'd7);
        wait_done();
        chk("neg_quot", held_q, 31'h4000000E);
        chk("neg_rem", held_r, 31'h40000002);
        start_op(1'b1, 30'd0, 30'd100, 1'b1, 30'd7);
        wait_done();
        chk("negneg_quot", held_q, 31'h0000000E);
        chk("negneg_rem", held_r, 31'h40000002);

        // Overflow, including divide by zero.
        start_op(1'b0, 30'd5, 30'd9, 1'b0, 30'd5);
        t0 = pend.start_cyc;
        wait_done();
        chk("ovf_flag", held_ovf, 1'b1);
        chk("ovf_quot", held_q, 31'h5);
        chk("ovf_rem", held_r, 31'h9);
        chk("ovf_lat", last_stop_cyc - t0, 2);
        start_op(1'b0, 30'd5, 30'd9, 1'b0, 30'd0);
        t0 = pend.start_cyc;
        wait_done();
        chk("div0_flag", held_ovf, 1'b1);
        chk("div0_lat", last_stop_cyc - t0, 2);

        // Maximum operands.
        start_op(1'b0, 30'h3FFFFFFE, 30'h3FFFFFFF, 1'b0, 30'h3FFFFFFF);
        wait_done();
        chk("max_quot", held_q, 31'h3FFFFFFF);
        chk("max_rem", held_r, 31'h3FFFFFFE);
        chk("max_ovf", held_ovf, 1'b0);

        // Restart at T+10 aborts the first division.
        start_op(1'b0, 30'd0, 30'd1000, 1'b0, 30'd7);
        t0 = pend.start_cyc;
        wait_until(t0 + 9);
        start_op(1'b0, 30'd0, 30'd17, 1'b0, 30'd3);
        wait_done();
        chk("restart_stop", last_stop_cyc, t0 + 42);
        chk("restart_quot", held_q, 31'h5);
        chk("restart_rem", held_r, 31'h2);

        // Start coincident with stop.
        start_op(1'b0, 30'd1, 30'd12345, 1'b1, 30'd999);
        s = pend.stop_cyc;
        wait_until(s - 1);
        start_op(1'b1, 30'd2, 30'd77, 1'b0, 30'd11);
        t0 = pend.start_cyc;
        wait_done();
        chk("b2b_start", t0, s);
        chk("b2b_lat", last_stop_cyc - t0, 32);

        // Reset mid-operation.
        start_op(1'b0, 30'd3, 30'd555, 1'b0, 30'd9);
        t0 = pend.start_cyc;
        wait_until(t0 + 15);
        reset = 1'b1;
        #1;
        chk("mid_rst_quot", bus.quot, 0);
        chk("mid_rst_rem", bus.rem, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        chk("mid_rst_stop", bus.stop, 0);
        chk("mid_rst_busy", bus.busy, 0);
        pend.valid = 1'b0;
        held_q = '0; held_r = '0; held_ovf = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_until(t0 + 40);
        start_op(1'b0, 30'd0, 30'd17, 1'b0, 30'd3);
        t0 = pend.start_cyc;
        wait_done();
        chk("post_rst_quot", held_q, 31'h5);
        chk("post_rst_rem", held_r, 31'h2);
        chk("post_rst_lat", last_stop_cyc - t0, 32);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
